cmd_sequencer: RTL and testbench

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

---
 rtl/cmd_sequencer_pkg.sv | 27 ++
 rtl/cmd_fifo.sv | 90 +++++++++
 rtl/cmd_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_cmd_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_sequencer_pkg.sv
// Shared definitions for the command sequencer: FSM states, error codes,
// positive-acknowledge byte and a saturating counter helper.
package cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_SNT  = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] ACK_BYTE = 8'hA5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: DEPTH x WIDTH FIFO with registered full/empty/count and a
// look-ahead of the entry behind the head so the sequencer can preload it.
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [WIDTH-1:0]           head_next,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A push is judged against the current-cycle full flag, even if a pop frees a slot.
    assign push_ok_s = push && !full_r;
    assign pop_ok_s  = pop && !empty_r;

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_MAX);
            empty_r <= (count_next_s == '0);
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head      = mem_r[rd_ptr_r];
    assign head_next = mem_r[rd_ptr_r + PTR_ONE];
    assign full      = full_r;
    assign empty     = empty_r;
    assign count     = count_r;

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: queues command words and issues them one at a time to a
// remote-comm transmitter, waiting for send completion and an acknowledge byte.
module cmd_sequencer
    import cmd_sequencer_pkg::*;
#(
    parameter int         DEPTH        = 8,
    parameter int         TIMEOUT_CLKS = 1_000_000,
    parameter logic [7:0] ACK          = ACK_BYTE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [15:0]             wr_cmd,
    input  logic                    start,
    input  logic                    abort,
    output logic [15:0]             cmd,
    output logic                    send_cmd,
    input  logic                    cmd_snt,
    input  logic                    resp_rdy,
    input  logic [7:0]              resp,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic [7:0]              cmds_done
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    state_t         state_r;
    state_t         next_state_s;
    logic [15:0]    cmd_r;
    logic [15:0]    next_cmd_s;
    logic           send_cmd_r;
    logic           busy_r;
    logic           done_r;
    logic           err_r;
    logic [1:0]     err_code_r;
    logic [7:0]     cmds_done_r;
    logic [TW-1:0]  tmo_r;
    logic [TW-1:0]  tmo_next_s;
    logic           tmo_hit_s;
    logic           pop_s;
    logic           clear_stats_s;
    logic           fail_s;
    logic [1:0]     fail_code_s;
    logic [15:0]    head_s;
    logic [15:0]    head_next_s;
    logic [CW-1:0]  count_s;
    logic           empty_s;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (wr_en),
        .push_data (wr_cmd),
        .pop       (pop_s),
        .head      (head_s),
        .head_next (head_next_s),
        .full      (full),
        .empty     (empty_s),
        .count     (count_s)
    );

    // tmo_r counts clocks since send_cmd rose; the last allowed clock is TIMEOUT_CLKS-1.
    assign tmo_hit_s = (tmo_r == TMO_LAST);

    // Next-state, queue pop and preloaded command word.
    always_comb begin
        next_state_s  = state_r;
        next_cmd_s    = cmd_r;
        pop_s         = 1'b0;
        clear_stats_s = 1'b0;
        fail_s        = 1'b0;
        fail_code_s   = ERR_NONE;
        if (abort) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        clear_stats_s = 1'b1;
                        if (empty_s) begin
                            next_state_s = ST_DONE;
                        end else begin
                            next_state_s = ST_ISSUE;
                            next_cmd_s   = head_s;
                        end
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    next_state_s = ST_WAIT_SNT;
                end
                ST_WAIT_SNT: begin
                    if (cmd_snt) begin
                        next_state_s = ST_WAIT_RESP;
                    end else if (tmo_hit_s) begin
                        next_state_s = ST_IDLE;
                        fail_s       = 1'b1;
                        fail_code_s  = ERR_TIMEOUT;
                    end else begin
                        next_state_s = ST_WAIT_SNT;
                    end
                end
                ST_WAIT_RESP: begin
                    if (resp_rdy && (resp == ACK)) begin
                        pop_s = 1'b1;
                        // A write landing with the last pop keeps the queue non-empty.
                        if ((count_s == CW'(1)) && !wr_en) begin
                            next_state_s = ST_DONE;
                        end else if (count_s == CW'(1)) begin
                            next_state_s = ST_ISSUE;
                            next_cmd_s   = wr_cmd;
                        end else begin
                            next_state_s = ST_ISSUE;
                            next_cmd_s   = head_next_s;
                        end
                    end else if (resp_rdy) begin
                        next_state_s = ST_IDLE;
                        fail_s       = 1'b1;
                        fail_code_s  = ERR_NACK;
                    end else if (tmo_hit_s) begin
                        next_state_s = ST_IDLE;
                        fail_s       = 1'b1;
                        fail_code_s  = ERR_TIMEOUT;
                    end else begin
                        next_state_s = ST_WAIT_RESP;
                    end
                end
                ST_DONE: begin
                    next_state_s = ST_IDLE;
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Timeout counter next value.
    always_comb begin
        tmo_next_s = '0;
        if (next_state_s == ST_ISSUE) begin
            tmo_next_s = '0;
        end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT_SNT) ||
                     (state_r == ST_WAIT_RESP)) begin
            tmo_next_s = tmo_r + TMO_ONE;
        end else begin
            tmo_next_s = '0;
        end
    end

    // State, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cmd_r       <= 16'h0000;
            send_cmd_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= ERR_NONE;
            cmds_done_r <= 8'd0;
            tmo_r       <= '0;
        end else begin
            state_r    <= next_state_s;
            cmd_r      <= next_cmd_s;
            send_cmd_r <= (next_state_s == ST_ISSUE);
            busy_r     <= (next_state_s != ST_IDLE);
            done_r     <= (next_state_s == ST_DONE);
            tmo_r      <= tmo_next_s;
            if (fail_s) begin
                err_r      <= 1'b1;
                err_code_r <= fail_code_s;
            end else if (clear_stats_s) begin
                err_r      <= 1'b0;
                err_code_r <= ERR_NONE;
            end
            if (clear_stats_s) begin
                cmds_done_r <= 8'd0;
            end else if (pop_s) begin
                cmds_done_r <= sat_inc8(cmds_done_r);
            end
        end
    end

    assign cmd       = cmd_r;
    assign send_cmd  = send_cmd_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign err_code  = err_code_r;
    assign cmds_done = cmds_done_r;
    assign empty     = empty_s;
    assign count     = count_s;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: expected command words are queued as
// stimulus is issued and a monitor checks every send_cmd strobe against them.
module tb_cmd_sequencer;
    import cmd_sequencer_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_cmd;
    logic        start;
    logic        abort;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  cmds_done;

    int n_checks = 0;
    int n_fail   = 0;
    int send_cnt = 0;
    int done_cnt = 0;
    logic [15:0] exp_q[$];

    cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TMO), .ACK(ACK_BYTE)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_cmd(wr_cmd),
        .start(start), .abort(abort), .cmd(cmd), .send_cmd(send_cmd),
        .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
        .full(full), .empty(empty), .count(count), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .cmds_done(cmds_done)
    );

    always #5 clk = ~clk;

    // Monitor: each send_cmd strobe must match the next expected command.
    always @(negedge clk) begin
        if (send_cmd) begin
            send_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_send: got cmd %h, required no send_cmd", cmd);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (cmd !== e) begin
                    n_fail++;
                    $display("FAIL send_cmd_value: got %h required %h", cmd, e);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] c);
        wr_en  = 1'b1;
        wr_cmd = c;
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_send(input string name);
        for (int i = 0; i < 20 && !send_cmd; i++) tick();
        if (!send_cmd) check({name, "_send_timeout"}, 32'd0, 32'd1);
    endtask

    // Complete one transaction: transmitter done, then response byte r.
    task automatic serve(input logic [7:0] r, input string name);
        wait_send(name);
        tick();
        cmd_snt = 1'b1;
        tick();
        cmd_snt  = 1'b0;
        resp_rdy = 1'b1;
        resp     = r;
        tick();
        resp_rdy = 1'b0;
        resp     = 8'h00;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd"},       32'(cmd),       32'h0);
        check({tag, "_send_cmd"},  32'(send_cmd),  32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_done"},      32'(done),      32'h0);
        check({tag, "_err"},       32'(err),       32'h0);
        check({tag, "_err_code"},  32'(err_code),  32'(ERR_NONE));
        check({tag, "_cmds_done"}, 32'(cmds_done), 32'h0);
        check({tag, "_empty"},     32'(empty),     32'h1);
        check({tag, "_count"},     32'(count),     32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int sends_before;
        int dones_before;
        rst_n = 1'b0; wr_en = 1'b0; wr_cmd = 16'h0; start = 1'b0; abort = 1'b0;
        cmd_snt = 1'b0; resp_rdy = 1'b0; resp = 8'h00;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_reset("reset");
        check("reset_full", 32'(full), 32'h0);

        // Two commands, both acknowledged
        wr(16'h0000); wr(16'h2003);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h2003);
        dones_before = done_cnt;
        pulse_start();
        check("t1_send_after_start", 32'(send_cmd), 32'h1);
        serve(ACK_BYTE, "t1a");
        serve(ACK_BYTE, "t1b");
        check("t1_done", 32'(done), 32'h1);
        check("t1_cmds_done", 32'(cmds_done), 32'd2);
        check("t1_empty", 32'(empty), 32'h1);
        tick();
        check("t1_busy_idle", 32'(busy), 32'h0);
        check("t1_done_pulses", 32'(done_cnt - dones_before), 32'd1);

        // NACK on second command, then retry
        wr(16'h1001); wr(16'h1002); wr(16'h1003);
        exp_q.push_back(16'h1001); exp_q.push_back(16'h1002);
        pulse_start();
        serve(ACK_BYTE, "t2a");
        serve(8'h5A, "t2b");
        check("t2_err", 32'(err), 32'h1);
        check("t2_err_code", 32'(err_code), 32'(ERR_NACK));
        check("t2_cmds_done", 32'(cmds_done), 32'd1);
        check("t2_count", 32'(count), 32'd2);
        check("t2_busy", 32'(busy), 32'h0);
        check("t2_cmd_held", 32'(cmd), 32'h1002);
        exp_q.push_back(16'h1002); exp_q.push_back(16'h1003);
        dones_before = done_cnt;
        pulse_start();
        check("t2_err_cleared", 32'(err), 32'h0);
        check("t2_code_cleared", 32'(err_code), 32'(ERR_NONE));
        serve(ACK_BYTE, "t2c");
        serve(ACK_BYTE, "t2d");
        check("t2_retry_done", 32'(done), 32'h1);
        check("t2_retry_cmds_done", 32'(cmds_done), 32'd2);
        tick();
        check("t2_done_pulses", 32'(done_cnt - dones_before), 32'd1);

        // Timeout with cmd_snt withheld
        wr(16'h3000);
        exp_q.push_back(16'h3000);
        pulse_start();
        wait_send("t3");
        for (int i = 0; i < TMO - 1; i++) tick();
        check("t3_no_err_before", 32'(err), 32'h0);
        check("t3_busy_before", 32'(busy), 32'h1);
        tick();
        check("t3_err", 32'(err), 32'h1);
        check("t3_err_code", 32'(err_code), 32'(ERR_TIMEOUT));
        check("t3_busy", 32'(busy), 32'h0);
        check("t3_count", 32'(count), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t3_abort_empty", 32'(empty), 32'h1);
        check("t3_err_kept", 32'(err), 32'h1);

        // Overfill: ninth write dropped
        for (int i = 0; i <= DEPTH; i++) wr(16'h4000 + 16'(i));
        check("t4_full", 32'(full), 32'h1);
        check("t4_count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(16'h4000 + 16'(i));
        pulse_start();
        for (int i = 0; i < DEPTH; i++) serve(ACK_BYTE, "t4");
        check("t4_done", 32'(done), 32'h1);
        check("t4_cmds_done", 32'(cmds_done), 32'(DEPTH));
        tick();
        sends_before = send_cnt;
        pulse_start();
        check("t4_empty_start_done", 32'(done), 32'h1);
        tick();
        check("t4_empty_no_send", 32'(send_cnt - sends_before), 32'd0);
        check("t4_idle", 32'(busy), 32'h0);

        // Reset in WAIT_RESP, then spurious response
        wr(16'h5001); wr(16'h5002);
        exp_q.push_back(16'h5001);
        pulse_start();
        wait_send("t5");
        tick();
        cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
        sends_before = send_cnt;
        rst_n = 1'b0;
        #2;
        check_reset("t5_async");
        #1;
        rst_n = 1'b1;
        resp_rdy = 1'b1; resp = ACK_BYTE;
        tick();
        resp_rdy = 1'b0; resp = 8'h00;
        tick(); tick();
        check_reset("t5_after");
        check("t5_no_send", 32'(send_cnt - sends_before), 32'd0);

        // Abort during WAIT_SNT with four queued
        for (int i = 0; i < 4; i++) wr(16'h6000 + 16'(i));
        exp_q.push_back(16'h6000);
        pulse_start();
        wait_send("t6");
        tick();
        dones_before = done_cnt;
        abort = 1'b1; tick(); abort = 1'b0;
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_empty", 32'(empty), 32'h1);
        check("t6_count", 32'(count), 32'd0);
        tick(); tick();
        check("t6_no_done", 32'(done_cnt - dones_before), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
